simd_alu_pipe: RTL and testbench



---
 rtl/simd_alu_pkg.sv | 24 ++
 rtl/simd_alu_pipe_lane_adder.sv | 45 ++++
 rtl/simd_alu_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_simd_alu_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
// Shared definitions for the SIMD ALU pipeline: opcode encodings and the
// lane saturation constants used by the lane adders.
package simd_alu_pkg;

   localparam logic [2:0] OP_AND    = 3'b000;
   localparam logic [2:0] OP_NOT    = 3'b001;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_SADD   = 3'b011;
   localparam logic [2:0] OP_LADD   = 3'b100;
   localparam logic [2:0] OP_ACC    = 3'b101;
   localparam logic [2:0] OP_CLRACC = 3'b110;
   localparam logic [2:0] OP_RSVD   = 3'b111;

   // Largest positive signed value of a lane (0x7F..F), zero-extended to 64 bits.
   function automatic logic [63:0] lane_sat_max(input int unsigned lane);
      return (64'd1 << (lane - 1)) - 64'd1;
   endfunction

   // Most negative signed value of a lane (0x80..0), zero-extended to 64 bits.
   function automatic logic [63:0] lane_sat_min(input int unsigned lane);
      return 64'd1 << (lane - 1);
   endfunction

endpackage

// File: rtl/simd_alu_pipe_lane_adder.sv
// One LANE-bit slice of the SIMD adder.
//   a, b      lane operands
//   cin       carry from the lane below
//   kill_cin  ignore cin (lane-wise ops keep lanes independent)
//   sat_en    clamp the sum to the signed lane range on overflow
//   sum       lane result (saturated when sat_en and ovf)
//   cout      raw carry out of the lane MSB
//   ovf       signed overflow: carry into MSB xor carry out of MSB
module lane_adder
   import simd_alu_pkg::*;
#(
   parameter int unsigned LANE = 8
) (
   input  logic [LANE-1:0] a,
   input  logic [LANE-1:0] b,
   input  logic            cin,
   input  logic            kill_cin,
   input  logic            sat_en,
   output logic [LANE-1:0] sum,
   output logic            cout,
   output logic            ovf
);

   localparam logic [LANE-1:0] SatMax = LANE'(lane_sat_max(LANE));
   localparam logic [LANE-1:0] SatMin = LANE'(lane_sat_min(LANE));

   logic            cin_eff;
   logic [LANE:0]   full;
   logic            c_msb;

   always_comb begin
      cin_eff = cin & ~kill_cin;
      full    = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin_eff};
      // The MSB sum bit is a^b^carry_in, so the carry into the MSB falls out directly.
      c_msb   = a[LANE-1] ^ b[LANE-1] ^ full[LANE-1];
      cout    = full[LANE];
      ovf     = c_msb ^ full[LANE];
      sum     = full[LANE-1:0];
      // On overflow both operands share a sign, so a's MSB picks the clamp direction.
      if (sat_en && ovf) begin
         sum = a[LANE-1] ? SatMin : SatMax;
      end
   end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU with accumulator and valid/ready on both sides.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready combinational from out_ready)
//   op, a, b             opcode and operands, captured into stage 1
//   out_valid/out_ready  result handshake
//   result, ovf, carry,  registered stage-2 result and flags
//   zero, err
module simd_alu_pipe
   import simd_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LANE  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              op,
   input  logic [WIDTH-1:0]        a,
   input  logic [WIDTH-1:0]        b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        result,
   output logic [WIDTH/LANE-1:0]   ovf,
   output logic                    carry,
   output logic                    zero,
   output logic                    err
);

   localparam int unsigned LANES = WIDTH / LANE;

   // Stage 1: captured operands.
   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;

   // Stage 2: registered result, flags and accumulator.
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [LANES-1:0] ovf_q, ovf_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic s2_adv, s1_adv, in_fire;

   // Shared adder inputs and outputs.
   logic             acc_op, kill_cin, sat_en;
   logic [WIDTH-1:0] add_a, add_b, sum_all;
   logic [LANES-1:0] lane_ovf;
   logic             top_cout;

   // Stage-2 combinational results.
   logic [WIDTH-1:0] res_c, acc_c;
   logic [LANES-1:0] ovf_c;
   logic             carry_c, err_c;

   always_comb begin
      acc_op   = (s1_op_q == OP_ACC);
      add_a    = acc_op ? acc_q  : s1_a_q;
      add_b    = acc_op ? s1_a_q : s1_b_q;
      // Only the full-width adds ripple carry across lane boundaries.
      kill_cin = (s1_op_q != OP_ADD) && (s1_op_q != OP_ACC);
      sat_en   = (s1_op_q == OP_SADD);
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic cin;
      logic cout;
      if (i == 0) begin : g_first
         assign cin = 1'b0;
      end else begin : g_chain
         assign cin = g_lane[i-1].cout;
      end
      lane_adder #(
         .LANE(LANE)
      ) u_lane (
         .a        (add_a[i*LANE +: LANE]),
         .b        (add_b[i*LANE +: LANE]),
         .cin      (cin),
         .kill_cin (kill_cin),
         .sat_en   (sat_en),
         .sum      (sum_all[i*LANE +: LANE]),
         .cout     (cout),
         .ovf      (lane_ovf[i])
      );
   end

   // With the chain intact the top lane's cout/ovf are the full-width carry/overflow.
   assign top_cout = g_lane[LANES-1].cout;

   always_comb begin
      res_c   = '0;
      ovf_c   = '0;
      carry_c = 1'b0;
      err_c   = 1'b0;
      acc_c   = acc_q;
      unique case (s1_op_q)
         OP_AND:  res_c = s1_a_q & s1_b_q;
         OP_NOT:  res_c = ~s1_b_q;
         OP_ADD: begin
            res_c            = sum_all;
            carry_c          = top_cout;
            ovf_c[LANES-1]   = lane_ovf[LANES-1];
         end
         OP_SADD, OP_LADD: begin
            res_c   = sum_all;
            carry_c = top_cout;
            ovf_c   = lane_ovf;
         end
         OP_ACC: begin
            res_c            = sum_all;
            carry_c          = top_cout;
            ovf_c[LANES-1]   = lane_ovf[LANES-1];
            acc_c            = sum_all;
         end
         OP_CLRACC: acc_c = '0;
         OP_RSVD:   err_c = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      s2_adv   = ~out_valid_q | out_ready;
      s1_adv   = s1_valid_q & s2_adv;
      in_ready = ~s1_valid_q | s2_adv;
      in_fire  = in_valid & in_ready;

      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_op_d    = op;
         s1_a_d     = a;
         s1_b_d     = b;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      out_valid_d = out_valid_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      err_d       = err_q;
      acc_d       = acc_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         // acc only moves when an op actually enters S2, so a stalled ACC cannot repeat.
         if (s1_valid_q) begin
            result_d = res_c;
            ovf_d    = ovf_c;
            carry_d  = carry_c;
            zero_d   = (res_c == '0);
            err_d    = err_c;
            acc_d    = acc_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_AND;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe: a 16/8 and a 32/8 instance share stimulus, selected by sel.
// Expected results come from a lane-arithmetic reference model and an in-order queue.
module tb_simd_alu_pipe;
   import simd_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        in_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] a, b;

   logic        in_ready16, out_valid16, carry16, zero16, err16;
   logic [15:0] result16;
   logic [1:0]  ovf16;
   logic        in_ready32, out_valid32, carry32, zero32, err32;
   logic [31:0] result32;
   logic [3:0]  ovf32;

   logic        obs_valid, obs_inr, obs_carry, obs_zero, obs_err;
   logic [31:0] obs_res;
   logic [3:0]  obs_ovf;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  ovf;
      logic        carry;
      logic        zero;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_acc;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   simd_alu_pipe #(.WIDTH(16), .LANE(8)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready16),
      .op(op), .a(a[15:0]), .b(b[15:0]), .out_valid(out_valid16), .out_ready(out_ready),
      .result(result16), .ovf(ovf16), .carry(carry16), .zero(zero16), .err(err16)
   );

   simd_alu_pipe #(.WIDTH(32), .LANE(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready32),
      .op(op), .a(a), .b(b), .out_valid(out_valid32), .out_ready(out_ready),
      .result(result32), .ovf(ovf32), .carry(carry32), .zero(zero32), .err(err32)
   );

   always_comb begin
      obs_valid = sel ? out_valid32 : out_valid16;
      obs_inr   = sel ? in_ready32  : in_ready16;
      obs_res   = sel ? result32    : {16'h0, result16};
      obs_ovf   = sel ? ovf32       : {2'b00, ovf16};
      obs_carry = sel ? carry32     : carry16;
      obs_zero  = sel ? zero32      : zero16;
      obs_err   = sel ? err32       : err16;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint sext(input longint v, input int n);
      return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
   endfunction

   // Reference: plain integer arithmetic on whole words and on individual lanes.
   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x_a, x_b,
                                  input int w, input int l, input logic [31:0] acc_in,
                                  output logic [31:0] acc_out);
      exp_t   e;
      longint mask, lmask, xa, xb, ua, ub, s, sa, sb, ss, hi, lo, u, res_l;
      int     lanes;
      logic   ov;
      mask  = (longint'(1) << w) - 1;
      lmask = (longint'(1) << l) - 1;
      lanes = w / l;
      xa    = longint'(x_a) & mask;
      xb    = longint'(x_b) & mask;
      e.res = '0; e.ovf = '0; e.carry = 1'b0; e.err = 1'b0; e.cyc = 0;
      acc_out = acc_in;
      case (o)
         OP_AND: e.res = 32'(xa & xb);
         OP_NOT: e.res = 32'(~xb & mask);
         OP_ADD, OP_ACC: begin
            ua = (o == OP_ACC) ? longint'(acc_in) : xa;
            ub = (o == OP_ACC) ? xa : xb;
            s  = ua + ub;
            e.res   = 32'(s & mask);
            e.carry = ((s >> w) & 1) != 0;
            ss = sext(ua, w) + sext(ub, w);
            hi = (longint'(1) << (w - 1)) - 1;
            lo = -(longint'(1) << (w - 1));
            e.ovf[lanes-1] = (ss > hi) || (ss < lo);
            if (o == OP_ACC) acc_out = e.res;
         end
         OP_SADD, OP_LADD: begin
            res_l = 0;
            hi = (longint'(1) << (l - 1)) - 1;
            lo = -(longint'(1) << (l - 1));
            for (int i = 0; i < lanes; i++) begin
               ua = (xa >> (i * l)) & lmask;
               ub = (xb >> (i * l)) & lmask;
               s  = ua + ub;
               u  = s & lmask;
               sa = sext(ua, l);
               sb = sext(ub, l);
               ss = sa + sb;
               ov = (ss > hi) || (ss < lo);
               if (ov && o == OP_SADD) u = (sa < 0) ? (longint'(1) << (l - 1)) : hi;
               res_l = res_l | (u << (i * l));
               e.ovf[i] = ov;
               if (i == lanes - 1) e.carry = ((s >> l) & 1) != 0;
            end
            e.res = 32'(res_l);
         end
         OP_CLRACC: acc_out = '0;
         default: e.err = 1'b1;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   // One cycle: drive at the falling edge, check settled outputs, update the queue.
   task automatic step(input logic v, input logic [2:0] o, input logic [31:0] aa, bb,
                       input logic rdy);
      exp_t        e;
      logic        exp_valid, exp_inr;
      logic [31:0] nacc;
      @(negedge clk);
      in_valid = v; op = o; a = aa; b = bb; out_ready = rdy;
      #1;
      // The oldest in-flight bundle is visible two edges after its accept edge.
      exp_valid = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
      // Only a full pipe with a stalled consumer refuses input.
      exp_inr   = !((q.size() == 2) && !rdy);
      chk("out_valid", {31'b0, obs_valid}, {31'b0, exp_valid});
      chk("in_ready", {31'b0, obs_inr}, {31'b0, exp_inr});
      if (exp_valid) begin
         chk("result", obs_res, q[0].res);
         chk("ovf", {28'b0, obs_ovf}, {28'b0, q[0].ovf});
         chk("carry", {31'b0, obs_carry}, {31'b0, q[0].carry});
         chk("zero", {31'b0, obs_zero}, {31'b0, q[0].zero});
         chk("err", {31'b0, obs_err}, {31'b0, q[0].err});
         if (rdy) void'(q.pop_front());
      end
      if (v && exp_inr) begin
         e = model(o, aa, bb, sel ? 32 : 16, 8, m_acc, nacc);
         m_acc = nacc;
         e.cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, OP_AND, '0, '0, 1'b1);
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, {31'b0, obs_valid}, 32'd0);
      chk({tag, "_result"}, obs_res, 32'd0);
      chk({tag, "_ovf"}, {28'b0, obs_ovf}, 32'd0);
      chk({tag, "_flags"}, {29'b0, obs_carry, obs_zero, obs_err}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      check_idle("rst");
      q.delete();
      m_acc = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = OP_AND; a = '0; b = '0; m_acc = '0;
      repeat (2) @(negedge clk);
      #1;
      check_idle("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed ops at full throughput.
      step(1'b1, OP_AND,    32'h0F0F, 32'hF0F0, 1'b1);
      step(1'b1, OP_NOT,    32'h0000, 32'hF0F0, 1'b1);
      step(1'b1, OP_SADD,   32'hCCCC, 32'h6666, 1'b1);
      step(1'b1, OP_SADD,   32'h7F80, 32'h0180, 1'b1);
      step(1'b1, OP_ADD,    32'hFFFF, 32'h0001, 1'b1);
      step(1'b1, OP_LADD,   32'hFFFF, 32'h0001, 1'b1);
      step(1'b1, OP_CLRACC, 32'h0000, 32'h0000, 1'b1);
      step(1'b1, OP_ACC,    32'h0003, 32'h0000, 1'b1);
      step(1'b1, OP_ACC,    32'h0005, 32'h0000, 1'b1);
      step(1'b1, OP_ACC,    32'h0007, 32'h0000, 1'b1);
      step(1'b1, OP_RSVD,   32'h1234, 32'h5678, 1'b1);
      drain();

      // Backpressure: ACC ops stalled in S2 must not re-update acc.
      step(1'b1, OP_ACC, 32'h0011, 32'h0, 1'b0);
      step(1'b1, OP_ACC, 32'h0022, 32'h0, 1'b0);
      step(1'b1, OP_ACC, 32'h0044, 32'h0, 1'b0);
      repeat (4) step(1'b0, OP_AND, 32'h0, 32'h0, 1'b0);
      step(1'b1, OP_ACC, 32'h0044, 32'h0, 1'b1);
      drain();

      // Random mix with random valid and backpressure.
      for (int i = 0; i < 300; i++) begin
         step(($urandom % 4) != 0, 3'($urandom), $urandom, $urandom, ($urandom % 3) != 0);
      end
      drain();

      // Reset in the middle of traffic, then confirm acc restarted at zero.
      step(1'b1, OP_ACC, 32'h0100, 32'h0, 1'b1);
      step(1'b1, OP_ACC, 32'h0200, 32'h0, 1'b1);
      do_reset();
      step(1'b1, OP_ACC, 32'h0005, 32'h0, 1'b1);
      drain();

      // 32-bit, 4-lane instance.
      do_reset();
      sel = 1'b1;
      step(1'b1, OP_SADD, 32'h7F80_7F80, 32'h0180_0180, 1'b1);
      step(1'b1, OP_SADD, 32'hCCCC_CCCC, 32'h6666_6666, 1'b1);
      step(1'b1, OP_LADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      step(1'b1, OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      for (int i = 0; i < 150; i++) begin
         step(1'b1, OP_SADD, $urandom, $urandom, ($urandom % 4) != 0);
      end
      for (int i = 0; i < 150; i++) begin
         step(($urandom % 4) != 0, 3'($urandom), $urandom, $urandom, ($urandom % 3) != 0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
